// File: rtl/cla_arbiter.sv
// Two-requester round-robin front end for a single shared 32-bit carry-lookahead adder.
// Operations are serialised: one grant, one execute cycle, one held response.

module cla_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] sum,
    output logic        co
);
    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] c;
    logic [8:0]  cg;

    assign g     = a & b;
    assign p     = a ^ b;
    assign cg[0] = ci;

    // 4-bit lookahead groups; group carries chain between groups
    for (genvar k = 0; k < 8; k++) begin : grp
        localparam int B = 4 * k;
        assign c[B]     = cg[k];
        assign c[B + 1] = g[B] | (p[B] & cg[k]);
        assign c[B + 2] = g[B + 1] | (p[B + 1] & g[B]) | (p[B + 1] & p[B] & cg[k]);
        assign c[B + 3] = g[B + 2] | (p[B + 2] & g[B + 1]) | (p[B + 2] & p[B + 1] & g[B])
                        | (p[B + 2] & p[B + 1] & p[B] & cg[k]);
        assign cg[k + 1] = g[B + 3] | (p[B + 3] & g[B + 2]) | (p[B + 3] & p[B + 2] & g[B + 1])
                         | (p[B + 3] & p[B + 2] & p[B + 1] & g[B])
                         | ((&p[B + 3:B]) & cg[k]);
    end

    assign sum = p ^ c;
    assign co  = cg[8];
endmodule

// state | meaning
// IDLE  | waiting for a valid request; ready goes to the granted requester
// EXEC  | adder driven from operand registers, result captured at edge
// RESP  | response held until rsp_ready
module cla_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic             req0_sub,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic             req1_sub,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_sum,
    output logic             rsp_co,
    output logic             rsp_ovf,
    output logic             rsp_id,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    state_t      state, state_nxt;
    logic        last_grant;
    logic        gnt_id;
    logic        hs;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic        sel_sub;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_ci;
    logic        op_id;
    logic [31:0] cla_sum;
    logic        cla_co;

    cla_32bit u_cla (
        .a   (op_a),
        .b   (op_b),
        .ci  (op_ci),
        .sum (cla_sum),
        .co  (cla_co)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        hs         = 1'b0;
        // with both valid the requester opposite the last winner goes
        gnt_id     = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        sel_a      = gnt_id ? req1_a   : req0_a;
        sel_b      = gnt_id ? req1_b   : req0_b;
        sel_sub    = gnt_id ? req1_sub : req0_sub;
        case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    req0_ready = ~gnt_id;
                    req1_ready = gnt_id;
                    hs         = 1'b1;
                    state_nxt  = EXEC;
                end
            end
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            op_a       <= '0;
            op_b       <= '0;
            op_ci      <= 1'b0;
            op_id      <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_sum    <= '0;
            rsp_co     <= 1'b0;
            rsp_ovf    <= 1'b0;
            rsp_id     <= 1'b0;
            cnt0       <= '0;
            cnt1       <= '0;
        end else begin
            if (hs) begin
                op_a       <= sel_a;
                op_b       <= sel_sub ? ~sel_b : sel_b;
                op_ci      <= sel_sub;
                op_id      <= gnt_id;
                last_grant <= gnt_id;
            end
            if (state == EXEC) begin
                rsp_valid <= 1'b1;
                rsp_sum   <= cla_sum;
                rsp_co    <= cla_co;
                rsp_ovf   <= (op_a[31] == op_b[31]) && (cla_sum[31] != op_a[31]);
                rsp_id    <= op_id;
            end
            if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
                if (rsp_id) begin
                    if (cnt1 != {CNT_W{1'b1}}) cnt1 <= cnt1 + CNT_W'(1);
                end else begin
                    if (cnt0 != {CNT_W{1'b1}}) cnt0 <= cnt0 + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_cla_arbiter.sv
// Transaction-level bench for cla_arbiter: random and directed operations checked
// against an arithmetic reference (signed/unsigned integer math, round-robin rule).

module tb_cla_arbiter;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req0_ready, req0_sub;
    logic [31:0]   req0_a, req0_b;
    logic          req1_valid, req1_ready, req1_sub;
    logic [31:0]   req1_a, req1_b;
    logic          rsp_valid, rsp_ready, rsp_co, rsp_ovf, rsp_id;
    logic [31:0]   rsp_sum;
    logic [CW-1:0] cnt0, cnt1;

    cla_arbiter #(.CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sub   (req0_sub),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sub   (req1_sub),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_sum    (rsp_sum),
        .rsp_co     (rsp_co),
        .rsp_ovf    (rsp_ovf),
        .rsp_id     (rsp_id),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    logic last_id;
    int   mcnt[2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] sum, output logic co, output logic ovf);
        longint sa, sb, r, lim;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        lim = 64'sd2147483647;
        r   = s ? sa - sb : sa + sb;
        sum = r[31:0];
        ovf = (r > lim) || (r < -lim - 1);
        co  = s ? (a >= b) : ((longint'(a) + longint'(b)) >= 64'sh1_0000_0000);
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    task automatic check_counts(input string tag);
        chk({tag, "_cnt0"}, 64'(cnt0), 64'(mcnt[0]));
        chk({tag, "_cnt1"}, 64'(cnt1), 64'(mcnt[1]));
    endtask

    // Presents one request set, follows the granted operation through to completion.
    task automatic transact(input logic v0, input logic v1,
                            input logic [31:0] a0, input logic [31:0] b0, input logic s0,
                            input logic [31:0] a1, input logic [31:0] b1, input logic s1,
                            input int bp, input logic hold);
        logic        eid, eco, eovf;
        logic [31:0] esum;
        rsp_ready  = 1'b0;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_sub = s0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_sub = s1;
        eid = (v0 && v1) ? ~last_id : v1;
        if (eid) model(a1, b1, s1, esum, eco, eovf);
        else     model(a0, b0, s0, esum, eco, eovf);
        #1;
        chk("grant_rdy0", 64'(req0_ready), 64'(!eid));
        chk("grant_rdy1", 64'(req1_ready), 64'(eid));
        @(posedge clk);
        last_id = eid;
        @(negedge clk);
        if (!hold) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
        req0_a = $urandom; req0_b = $urandom; req0_sub = 1'($urandom);
        req1_a = $urandom; req1_b = $urandom; req1_sub = 1'($urandom);
        #1;
        chk("exec_valid", 64'(rsp_valid), 64'd0);
        chk("exec_rdy", 64'({req0_ready, req1_ready}), 64'd0);
        @(negedge clk);
        chk("rsp_valid", 64'(rsp_valid), 64'd1);
        chk("rsp_sum", 64'(rsp_sum), 64'(esum));
        chk("rsp_co", 64'(rsp_co), 64'(eco));
        chk("rsp_ovf", 64'(rsp_ovf), 64'(eovf));
        chk("rsp_id", 64'(rsp_id), 64'(eid));
        for (int k = 0; k < bp; k++) begin
            @(negedge clk);
            chk("bp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_sum", 64'({rsp_sum, rsp_co, rsp_ovf, rsp_id}), 64'({esum, eco, eovf, eid}));
            chk("bp_rdy", 64'({req0_ready, req1_ready}), 64'd0);
            check_counts("bp");
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        if (mcnt[eid] < CMAX) mcnt[eid]++;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("done_valid", 64'(rsp_valid), 64'd0);
        check_counts("done");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] pat;
        rst_n = 1'b0; rsp_ready = 1'b0;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_sub = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_sub = 0;
        last_id = 1'b1; mcnt[0] = 0; mcnt[1] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp", 64'({rsp_sum, rsp_co, rsp_ovf, rsp_id}), 64'd0);
        chk("rst_rdy", 64'({req0_ready, req1_ready}), 64'd0);
        check_counts("rst");

        // directed arithmetic cases
        transact(1, 0, 32'h5AF25A5E, 32'h0, 0, 0, 0, 0, 0, 0);
        transact(0, 1, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0);
        transact(0, 1, 0, 0, 0, 32'd5, 32'd3, 1, 0, 0);
        transact(0, 1, 0, 0, 0, 32'd0, 32'd1, 1, 0, 0);
        transact(1, 0, 32'h7FFFFFFF, 32'h1, 0, 0, 0, 0, 0, 0);
        transact(1, 0, 32'h80000000, 32'h1, 1, 0, 0, 0, 0, 0);
        transact(1, 0, 32'h0, 32'h0, 1, 0, 0, 0, 0, 0);

        // backpressure
        transact(0, 1, 0, 0, 0, 32'h1234, 32'h4321, 0, 5, 0);

        // reset while in RESP, then contention from reset
        req0_valid = 1; req1_valid = 1;
        req0_a = 32'd10; req0_b = 32'd20; req0_sub = 0;
        req1_a = 32'd30; req1_b = 32'd40; req1_sub = 1;
        repeat (2) @(negedge clk);
        #1;
        chk("pre_rst_valid", 64'(rsp_valid), 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        last_id = 1'b1; mcnt[0] = 0; mcnt[1] = 0;
        #1;
        chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
        check_counts("mid_rst");
        chk("mid_rst_rdy", 64'({req0_ready, req1_ready}), 64'b10);
        for (int i = 0; i < 4; i++)
            transact(1, 1, 32'd100 + 32'(i), 32'd7, 1, 32'd200 + 32'(i), 32'd9, 0, 0, 1);
        chk("cont_cnt0", 64'(cnt0), 64'd2);
        chk("cont_cnt1", 64'(cnt1), 64'd2);

        // randomized mix of contention, operands, backpressure
        for (int i = 0; i < 40; i++) begin
            pat = 2'($urandom_range(1, 3));
            transact(pat[0], pat[1], rnd32(), rnd32(), 1'($urandom), rnd32(), rnd32(),
                     1'($urandom), $urandom_range(0, 3), 1'($urandom));
        end

        // drive requester 0 past counter saturation
        for (int i = 0; i < CMAX + 2; i++)
            transact(1, 0, $urandom, $urandom, 0, 0, 0, 0, 0, 0);
        chk("sat_cnt0", 64'(cnt0), 64'(CMAX));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cla_arbiter.md
Name: cla_arbiter

Overview:
- Shares one CLA_32bit instance between two requesters. Each requester uses a valid/ready operand channel.
- Grants are round-robin and operations run one at a time. Subtract is done by inverting B and forcing carry-in.
- A registered response carries sum, carry and signed overflow, with backpressure and a requester ID.
- Sits between requesting datapath blocks and the shared adder; per-requester completed-operation counters support debug and performance checks.

Parameters:
CNT_W, 16, width of each per-requester completed-operation counter (saturating).

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_a  in  32  requester 0 operand A
req0_b  in  32  requester 0 operand B
req0_sub  in  1  1 = A-B, 0 = A+B
req1_valid  in  1  requester 1 has an operation
req1_ready  out  1  requester 1 operation accepted this cycle
req1_a  in  32  requester 1 operand A
req1_b  in  32  requester 1 operand B
req1_sub  in  1  1 = A-B, 0 = A+B
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts response
rsp_sum  out  32  result
rsp_co  out  1  adder carry-out (for sub: 1 = no borrow)
rsp_ovf  out  1  signed overflow
rsp_id  out  1  requester that issued the operation
cnt0  out  CNT_W  completed operations, requester 0
cnt1  out  CNT_W  completed operations, requester 1

Behaviour:
- Reset applies when rst_n=0 at a rising edge. Its effects:
  - state=IDLE and last_grant=1, so requester 0 wins first contention.
  - rsp_valid=0, rsp_sum=0, rsp_co=0, rsp_ovf=0, rsp_id=0, cnt0=0, cnt1=0.
  - Operand registers are cleared to 0.
- The state machine has three states: IDLE, EXEC and RESP.
- IDLE:
  - reqN_ready is combinational and high only in IDLE, only for the granted requester, and only when that requester's reqN_valid is 1.
  - Grant rule: if only one valid is high, grant it. If both are high, grant the one opposite last_grant.
  - On the handshake, register a, b_eff = sub ? ~b : b, ci = sub, and id. Update last_grant to id, then go to EXEC.
  - If no valid is high, stay in IDLE.
- EXEC:
  - The CLA is driven from the operand registers.
  - Capture the results at the clock edge: rsp_sum=sum, rsp_co=co, rsp_ovf = (a[31]==b_eff[31]) && (sum[31]!=a[31]), rsp_id=id.
  - Set rsp_valid=1 and go to RESP.
- RESP:
  - rsp_* are held stable while rsp_valid=1 and rsp_ready=0.
  - When rsp_ready=1, clear rsp_valid, increment cnt[rsp_id] (saturating at all-ones) and go to IDLE.
  - No new grant is made in the RESP cycle. Minimum spacing is 3 cycles per operation.
- Latency: handshake at edge T, rsp_valid high after edge T+1. With rsp_ready held at 1, the response completes at edge T+2.
- reqN_ready is never asserted outside IDLE. A requester that deasserts valid before handshake loses nothing.
- Operand values on req ports are ignored except in the handshake cycle.
- Reset mid-operation (EXEC or RESP): the pending result is discarded and no counter increments. The first grant after reset goes to requester 0.
- Counters stick at 2^CNT_W-1 and do not wrap.
- Arithmetic is modulo 2^32; rsp_co is the raw CLA carry-out. For sub, 0-0 gives co=1 and ovf=0.

Test Plan:
- Requester 0 add A=0x5AF25A5E, B=0 -> rsp_sum=0x5AF25A5E, co=0, ovf=0, id=0. rsp_valid rises exactly 1 cycle after the handshake; cnt0=1.
- Requester 1 add A=0xFFFFFFFF, B=0xFFFFFFFF -> sum=0xFFFFFFFE, co=1, ovf=0, id=1. Then sub 5-3 -> sum=2, co=1. Then sub 0-1 -> sum=0xFFFFFFFF, co=0, ovf=0.
- Overflow: add 0x7FFFFFFF+1 -> sum=0x80000000, ovf=1, co=0. Sub 0x80000000-1 -> sum=0x7FFFFFFF, ovf=1, co=1.
- Contention: both valid from reset and held -> grants alternate 0,1,0,1. After 4 ops cnt0=2 and cnt1=2; req1_ready never coincides with req0_ready.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_* stable, both readies low, no counter change. Release -> one increment, then the next grant.
- Reset pulse (rst_n=0 for 1 cycle) while in RESP -> rsp_valid=0 next cycle, counters 0; with both valid, the first grant goes to requester 0.
